// File: rtl/fu_div_pkg.sv
// Shared types and constants for the EX-stage iterative divider scheduler.
package fu_div_pkg;

  typedef enum logic [1:0] {
    DIV_W  = 2'b00,
    MOD_W  = 2'b01,
    DIV_WU = 2'b10,
    MOD_WU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int          DIV_ITER = 32;
  localparam logic [31:0] DIV0_Q   = 32'hFFFF_FFFF;

  function automatic logic op_signed(input div_op_t op);
    return !op[1];
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/fu_div_div_step.sv
// One combinational restoring-divide iteration: shift in the next dividend bit,
// subtract the divisor if it fits, and record the quotient bit.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quot,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quot_next
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  assign shifted = {rem, quot[DATA_W-1]};
  assign diff    = shifted - {1'b0, divisor};

  // rem < divisor keeps shifted < 2*divisor, so diff's top bit is a clean borrow flag
  always_comb begin
    rem_next  = shifted[DATA_W-1:0];
    quot_next = {quot[DATA_W-2:0], 1'b0};
    if (!diff[DATA_W]) begin
      rem_next  = diff[DATA_W-1:0];
      quot_next = {quot[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/fu_div_ctrl.sv
// Shared iterative divider sequencer for issue slots A and B (A served first).
// Optional macro DIV_EARLY_OUT_EN: finish a slot in one cycle when divisor is 0 or exceeds the dividend.
//
// state | meaning
// IDLE  | waiting for a request; accept latches both slots
// RUN_A | iterating slot A, counter 0..ITER-1
// RUN_B | iterating slot B, counter 0..ITER-1
// DONE  | stall released, valid pulse for each latched slot
module fu_div_ctrl
  import fu_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER   = DIV_ITER
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              EX_flush,
  input  logic              EX_div_req_a,
  input  logic [1:0]        EX_div_op_a,
  input  logic [DATA_W-1:0] EX_div_src_a1,
  input  logic [DATA_W-1:0] EX_div_src_a2,
  input  logic              EX_div_req_b,
  input  logic [1:0]        EX_div_op_b,
  input  logic [DATA_W-1:0] EX_div_src_b1,
  input  logic [DATA_W-1:0] EX_div_src_b2,
  output logic              EX_div_stall,
  output logic              EX_div_valid_a,
  output logic [DATA_W-1:0] EX_div_result_a,
  output logic              EX_div_valid_b,
  output logic [DATA_W-1:0] EX_div_result_b
);

  localparam int CNT_W = $clog2(ITER);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              lat_req_a, lat_req_b;
  div_op_t           op_a_q, op_b_q;
  logic [DATA_W-1:0] src_a1_q, src_a2_q, src_b1_q, src_b2_q;
  logic [DATA_W-1:0] rem_q, quot_q;
  logic              accept, running, last, early, cur_b;
  div_op_t           cur_op;
  logic [DATA_W-1:0] n, d, n_mag, d_mag;
  logic              n_neg, d_neg, div0;
  logic [DATA_W-1:0] step_rem, step_quot, rem_next, quot_next, res;

  assign cur_b   = (state_q == RUN_B);
  assign running = (state_q == RUN_A) || (state_q == RUN_B);
  assign cur_op  = cur_b ? op_b_q   : op_a_q;
  assign n       = cur_b ? src_b1_q : src_a1_q;
  assign d       = cur_b ? src_b2_q : src_a2_q;
  assign n_neg   = op_signed(cur_op) & n[DATA_W-1];
  assign d_neg   = op_signed(cur_op) & d[DATA_W-1];
  assign n_mag   = n_neg ? -n : n;
  assign d_mag   = d_neg ? -d : d;
  assign div0    = (d == '0);

  // Counter 0 is the slot's first iteration: seed the step from the operands, not stale regs
  assign step_rem  = (cnt_q == '0) ? '0    : rem_q;
  assign step_quot = (cnt_q == '0) ? n_mag : quot_q;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem       (step_rem),
    .quot      (step_quot),
    .divisor   (d_mag),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

`ifdef DIV_EARLY_OUT_EN
  assign early = (cnt_q == '0) && (div0 || (d_mag > n_mag));
`else
  assign early = 1'b0;
`endif

  assign last = early || (cnt_q == CNT_W'(ITER - 1));

  always_comb begin
    res = (n_neg ^ d_neg) ? -quot_next : quot_next;
    if (op_is_rem(cur_op))
      res = n_neg ? -rem_next : rem_next;
    if (div0)
      res = op_is_rem(cur_op) ? n : DIV0_Q[DATA_W-1:0];
    else if (early)
      res = op_is_rem(cur_op) ? n : '0;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    EX_div_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if ((EX_div_req_a || EX_div_req_b) && !EX_flush) begin
          accept       = 1'b1;
          EX_div_stall = 1'b1;
          state_d      = EX_div_req_a ? RUN_A : RUN_B;
        end
      end
      RUN_A: begin
        EX_div_stall = 1'b1;
        if (last) state_d = lat_req_b ? RUN_B : DONE;
      end
      RUN_B: begin
        EX_div_stall = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (EX_flush) state_d = IDLE;
  end

  assign EX_div_valid_a = (state_q == DONE) && lat_req_a && !EX_flush;
  assign EX_div_valid_b = (state_q == DONE) && lat_req_b && !EX_flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      lat_req_a       <= 1'b0;
      lat_req_b       <= 1'b0;
      op_a_q          <= DIV_W;
      op_b_q          <= DIV_W;
      src_a1_q        <= '0;
      src_a2_q        <= '0;
      src_b1_q        <= '0;
      src_b2_q        <= '0;
      rem_q           <= '0;
      quot_q          <= '0;
      EX_div_result_a <= '0;
      EX_div_result_b <= '0;
    end else begin
      state_q <= state_d;
      if (EX_flush || accept || (running && last))
        cnt_q <= '0;
      else if (running)
        cnt_q <= cnt_q + CNT_W'(1);
      if (accept) begin
        lat_req_a <= EX_div_req_a;
        lat_req_b <= EX_div_req_b;
        op_a_q    <= div_op_t'(EX_div_op_a);
        op_b_q    <= div_op_t'(EX_div_op_b);
        src_a1_q  <= EX_div_src_a1;
        src_a2_q  <= EX_div_src_a2;
        src_b1_q  <= EX_div_src_b1;
        src_b2_q  <= EX_div_src_b2;
      end
      if (running) begin
        rem_q  <= rem_next;
        quot_q <= quot_next;
      end
      if (running && last && !EX_flush) begin
        if (cur_b) EX_div_result_b <= res;
        else       EX_div_result_a <= res;
      end
    end
  end

endmodule

// File: tb/tb_fu_div_ctrl.sv
// Randomized self-checking bench for fu_div_ctrl against an arithmetic reference model.
module tb_fu_div_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        EX_flush = 1'b0;
  logic        EX_div_req_a = 1'b0, EX_div_req_b = 1'b0;
  logic [1:0]  EX_div_op_a = '0, EX_div_op_b = '0;
  logic [31:0] EX_div_src_a1 = '0, EX_div_src_a2 = '0, EX_div_src_b1 = '0, EX_div_src_b2 = '0;
  logic        EX_div_stall, EX_div_valid_a, EX_div_valid_b;
  logic [31:0] EX_div_result_a, EX_div_result_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_res_a = '0, exp_res_b = '0;

  always #5 clk = ~clk;

  fu_div_ctrl dut (
    .clk(clk), .rstn(rstn), .EX_flush(EX_flush),
    .EX_div_req_a(EX_div_req_a), .EX_div_op_a(EX_div_op_a),
    .EX_div_src_a1(EX_div_src_a1), .EX_div_src_a2(EX_div_src_a2),
    .EX_div_req_b(EX_div_req_b), .EX_div_op_b(EX_div_op_b),
    .EX_div_src_b1(EX_div_src_b1), .EX_div_src_b2(EX_div_src_b2),
    .EX_div_stall(EX_div_stall),
    .EX_div_valid_a(EX_div_valid_a), .EX_div_result_a(EX_div_result_a),
    .EX_div_valid_b(EX_div_valid_b), .EX_div_result_b(EX_div_result_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      2'b00: if (b == 0) return 32'hFFFF_FFFF;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
             else return 32'(sa / sb);
      2'b01: if (b == 0) return a;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
             else return 32'(sa % sb);
      2'b10: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int slot_cycles(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    longint ma, mb;
    if (op[1]) begin
      ma = longint'({32'b0, a});
      mb = longint'({32'b0, b});
    end else begin
      ma = longint'($signed(a));
      mb = longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
    end
    if (b == 0 || mb > ma) return 1;
`else
    if (op == 2'b00 && a == b) return 32;
`endif
    return 32;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic ra, input logic [1:0] oa, input logic [31:0] a1, input logic [31:0] a2,
                       input logic rb, input logic [1:0] ob, input logic [31:0] b1, input logic [31:0] b2);
    EX_div_req_a = ra; EX_div_op_a = oa; EX_div_src_a1 = a1; EX_div_src_a2 = a2;
    EX_div_req_b = rb; EX_div_op_b = ob; EX_div_src_b1 = b1; EX_div_src_b2 = b2;
  endtask

  task automatic run_txn(input logic ra, input logic [1:0] oa, input logic [31:0] a1, input logic [31:0] a2,
                         input logic rb, input logic [1:0] ob, input logic [31:0] b1, input logic [31:0] b2,
                         input bit flush_done);
    int exp_cyc, cyc;
    bit done;
    exp_cyc = 1 + (ra ? slot_cycles(oa, a1, a2) : 0) + (rb ? slot_cycles(ob, b1, b2) : 0);
    @(negedge clk);
    drive(ra, oa, a1, a2, rb, ob, b1, b2);
    #1 chk("stall_accept", 32'(EX_div_stall), 32'd1);
    cyc = 0;
    done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      #1;
      if (!EX_div_stall) done = 1;
    end
    if (!done) begin
      chk("timeout", 32'd0, 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      return;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    if (ra) exp_res_a = model(oa, a1, a2);
    if (rb) exp_res_b = model(ob, b1, b2);
    chk("done_cycle", 32'(cyc), 32'(exp_cyc));
    if (flush_done) begin
      EX_div_flush_pulse();
    end else begin
      chk("valid_a", 32'(EX_div_valid_a), 32'(ra));
      chk("valid_b", 32'(EX_div_valid_b), 32'(rb));
    end
    chk("result_a", EX_div_result_a, exp_res_a);
    chk("result_b", EX_div_result_b, exp_res_b);
    @(negedge clk);
    EX_flush = 1'b0;
    #1 chk("valid_after", 32'({EX_div_valid_a, EX_div_valid_b}), 32'd0);
  endtask

  task automatic EX_div_flush_pulse();
    EX_flush = 1'b1;
    #1 chk("flush_done_valid", 32'({EX_div_valid_a, EX_div_valid_b}), 32'd0);
  endtask

  initial begin
    logic r0, r1;
    logic [1:0] o0, o1;
    #2 chk("rst_stall", 32'(EX_div_stall), 32'd0);
    chk("rst_valid", 32'({EX_div_valid_a, EX_div_valid_b}), 32'd0);
    chk("rst_res_a", EX_div_result_a, 32'd0);
    chk("rst_res_b", EX_div_result_b, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_txn(1, 2'b00, -32'd7, 32'd2, 0, 0, 0, 0, 0);
    chk("dir_div_neg", EX_div_result_a, 32'hFFFF_FFFD);
    run_txn(1, 2'b01, -32'd7, 32'd2, 1, 2'b10, 32'd100, 32'd7, 0);
    chk("dir_mod_neg", EX_div_result_a, 32'hFFFF_FFFF);
    chk("dir_divu", EX_div_result_b, 32'h0000_000E);
    run_txn(0, 0, 0, 0, 1, 2'b11, 32'hFFFF_FFFF, 32'd16, 0);
    chk("dir_modu", EX_div_result_b, 32'h0000_000F);
    run_txn(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    chk("dir_ovf", EX_div_result_a, 32'h8000_0000);
    run_txn(1, 2'b00, 32'd5, 32'd0, 0, 0, 0, 0, 0);
    chk("dir_div0", EX_div_result_a, 32'hFFFF_FFFF);
    run_txn(1, 2'b01, 32'd5, 32'd0, 0, 0, 0, 0, 0);
    chk("dir_mod0", EX_div_result_a, 32'd5);
    run_txn(1, 2'b10, 32'd3, 32'd10, 0, 0, 0, 0, 0);
    chk("dir_small", EX_div_result_a, 32'd0);

    // flush at RUN_A counter 10 (cycle 11 after accept)
    @(negedge clk);
    drive(1, 2'b10, 32'd1000, 32'd3, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    EX_flush = 1'b1;
    #1 chk("flush_run_valid", 32'(EX_div_valid_a), 32'd0);
    @(negedge clk);
    EX_flush = 1'b0;
    #1 chk("flush_stall", 32'(EX_div_stall), 32'd0);
    chk("flush_res_a", EX_div_result_a, exp_res_a);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 if (EX_div_valid_a || EX_div_stall) begin
        chk("flush_no_restart", 32'({EX_div_valid_a, EX_div_stall}), 32'd0);
        break;
      end
    end
    run_txn(1, 2'b10, 32'd1000, 32'd3, 0, 0, 0, 0, 0);

    // flush in IDLE with a request present
    @(negedge clk);
    drive(1, 2'b00, 32'd9, 32'd3, 1, 2'b00, 32'd8, 32'd2);
    EX_flush = 1'b1;
    #1 chk("idle_flush_stall", 32'(EX_div_stall), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    EX_flush = 1'b0;
    #1 chk("idle_flush_noacc", 32'(EX_div_stall), 32'd0);

    for (int t = 0; t < 40; t++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      o0 = 2'($urandom_range(0, 3));
      o1 = 2'($urandom_range(0, 3));
      run_txn(r0, o0, pick(), pick(), r1, o1, pick(), pick(), ($urandom_range(0, 7) == 0));
    end

    // reset during RUN_B
    @(negedge clk);
    drive(1, 2'b00, 32'd77, 32'd5, 1, 2'b11, 32'd77, 32'd5);
    for (int i = 0; i < 40; i++) @(negedge clk);
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rstrun_stall", 32'(EX_div_stall), 32'd0);
    chk("rstrun_valid", 32'({EX_div_valid_a, EX_div_valid_b}), 32'd0);
    chk("rstrun_res_a", EX_div_result_a, 32'd0);
    chk("rstrun_res_b", EX_div_result_b, 32'd0);
    exp_res_a = '0;
    exp_res_b = '0;
    @(negedge clk);
    rstn = 1'b1;
    run_txn(1, 2'b01, 32'd100, -32'd7, 1, 2'b00, -32'd100, 32'd7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
